// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage.
//   InstructionSetALU : one-hot ALU control word (primary op plus branch compare op)
//   decoded_instr_t   : everything the issue slot holds for one instruction
//   OPC_* / F3_* / F7_*: RV32I encoding constants used by the decoder
package alu_issue_stage_pkg;

    localparam int XLEN_W = 32;

    typedef struct packed {
        logic ADD;
        logic SUB;
        logic SLL;
        logic SLT;
        logic SLTU;
        logic XOR;
        logic SRL;
        logic SRA;
        logic OR;
        logic AND;
        logic SEQ_B;
        logic SLT_B;
        logic SLTU_B;
    } InstructionSetALU;

    localparam int ALU_OP_W = $bits(InstructionSetALU);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        InstructionSetALU    alu_op;
        logic [XLEN_W-1:0]   in1;
        logic [XLEN_W-1:0]   in2;
        logic [XLEN_W-1:0]   in1_b;
        logic [XLEN_W-1:0]   in2_b;
        logic [4:0]          rd;
        logic                reg_write;
        logic                is_branch;
        logic                branch_invert;
        logic                is_jump;
        logic                illegal;
    } decoded_instr_t;

    // LB, LH, LW, LBU, LHU are the only defined load widths.
    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // SB, SH, SW are the only defined store widths.
    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    endfunction

endpackage

// File: rtl/alu_instr_decoder.sv
// Combinational RV32I decoder producing the ALU control word and operands.
//   instr    : instruction word
//   pc       : address of instr
//   rs1_data : register value for instr[19:15]
//   rs2_data : register value for instr[24:20]
//   dec      : decoded fields (one-hot op, four operands, rd, flags)
module alu_instr_decoder
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic [XLEN_W-1:0] pc,
    input  logic [XLEN_W-1:0] rs1_data,
    input  logic [XLEN_W-1:0] rs2_data,
    output decoded_instr_t    dec
);

    logic [6:0]        opcode_s;
    logic [2:0]        f3_s;
    logic [6:0]        f7_s;
    logic [4:0]        shamt_s;
    logic [XLEN_W-1:0] imm_i_s;
    logic [XLEN_W-1:0] imm_s_s;
    logic [XLEN_W-1:0] imm_b_s;
    logic [XLEN_W-1:0] imm_u_s;
    logic [XLEN_W-1:0] imm_j_s;
    logic              illegal_s;
    decoded_instr_t    d_s;

    assign opcode_s = instr[6:0];
    assign f3_s     = instr[14:12];
    assign f7_s     = instr[31:25];
    assign shamt_s  = instr[24:20];
    assign imm_i_s  = {{(XLEN_W-12){instr[31]}}, instr[31:20]};
    assign imm_s_s  = {{(XLEN_W-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b_s  = {{(XLEN_W-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u_s  = XLEN_W'($signed({instr[31:12], 12'h000}));
    assign imm_j_s  = {{(XLEN_W-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Opcode decode; anything unrecognised collapses to an all-zero NOP with illegal set.
    always_comb begin
        d_s       = '0;
        illegal_s = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                d_s.in1       = rs1_data;
                d_s.in2       = rs2_data;
                d_s.reg_write = 1'b1;
                if (f7_s == F7_BASE) begin
                    case (f3_s)
                        F3_ADD_SUB: d_s.alu_op.ADD  = 1'b1;
                        F3_SLL:     d_s.alu_op.SLL  = 1'b1;
                        F3_SLT:     d_s.alu_op.SLT  = 1'b1;
                        F3_SLTU:    d_s.alu_op.SLTU = 1'b1;
                        F3_XOR:     d_s.alu_op.XOR  = 1'b1;
                        F3_SR:      d_s.alu_op.SRL  = 1'b1;
                        F3_OR:      d_s.alu_op.OR   = 1'b1;
                        F3_AND:     d_s.alu_op.AND  = 1'b1;
                        default:    illegal_s       = 1'b1;
                    endcase
                end else if (f7_s == F7_ALT) begin
                    case (f3_s)
                        F3_ADD_SUB: d_s.alu_op.SUB = 1'b1;
                        F3_SR:      d_s.alu_op.SRA = 1'b1;
                        default:    illegal_s      = 1'b1;
                    endcase
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                d_s.in1       = rs1_data;
                d_s.in2       = imm_i_s;
                d_s.reg_write = 1'b1;
                case (f3_s)
                    F3_ADD_SUB: d_s.alu_op.ADD  = 1'b1;
                    F3_SLT:     d_s.alu_op.SLT  = 1'b1;
                    F3_SLTU:    d_s.alu_op.SLTU = 1'b1;
                    F3_XOR:     d_s.alu_op.XOR  = 1'b1;
                    F3_OR:      d_s.alu_op.OR   = 1'b1;
                    F3_AND:     d_s.alu_op.AND  = 1'b1;
                    F3_SLL: begin
                        d_s.in2 = XLEN_W'(shamt_s);
                        if (f7_s == F7_BASE) begin
                            d_s.alu_op.SLL = 1'b1;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    F3_SR: begin
                        d_s.in2 = XLEN_W'(shamt_s);
                        if (f7_s == F7_BASE) begin
                            d_s.alu_op.SRL = 1'b1;
                        end else if (f7_s == F7_ALT) begin
                            d_s.alu_op.SRA = 1'b1;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_LUI: begin
                d_s.alu_op.ADD = 1'b1;
                d_s.in2        = imm_u_s;
                d_s.reg_write  = 1'b1;
            end
            OPC_AUIPC: begin
                d_s.alu_op.ADD = 1'b1;
                d_s.in1        = pc;
                d_s.in2        = imm_u_s;
                d_s.reg_write  = 1'b1;
            end
            OPC_JAL: begin
                d_s.alu_op.ADD = 1'b1;
                d_s.in1        = pc;
                d_s.in2        = imm_j_s;
                d_s.is_jump    = 1'b1;
                d_s.reg_write  = 1'b1;
            end
            OPC_JALR: begin
                d_s.alu_op.ADD = 1'b1;
                d_s.in1        = rs1_data;
                d_s.in2        = imm_i_s;
                d_s.is_jump    = 1'b1;
                d_s.reg_write  = 1'b1;
                if (f3_s != F3_JALR) begin
                    illegal_s = 1'b1;
                end else begin
                    illegal_s = 1'b0;
                end
            end
            OPC_BRANCH: begin
                // Primary ALU path computes the target; the _b path does the compare.
                d_s.alu_op.ADD = 1'b1;
                d_s.in1        = pc;
                d_s.in2        = imm_b_s;
                d_s.in1_b      = rs1_data;
                d_s.in2_b      = rs2_data;
                d_s.is_branch  = 1'b1;
                case (f3_s)
                    F3_BEQ:  d_s.alu_op.SEQ_B = 1'b1;
                    F3_BNE: begin
                        d_s.alu_op.SEQ_B  = 1'b1;
                        d_s.branch_invert = 1'b1;
                    end
                    F3_BLT:  d_s.alu_op.SLT_B = 1'b1;
                    F3_BGE: begin
                        d_s.alu_op.SLT_B  = 1'b1;
                        d_s.branch_invert = 1'b1;
                    end
                    F3_BLTU: d_s.alu_op.SLTU_B = 1'b1;
                    F3_BGEU: begin
                        d_s.alu_op.SLTU_B = 1'b1;
                        d_s.branch_invert = 1'b1;
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d_s.alu_op.ADD = 1'b1;
                d_s.in1        = rs1_data;
                d_s.in2        = imm_i_s;
                d_s.reg_write  = 1'b1;
                illegal_s      = !load_f3_ok(f3_s);
            end
            OPC_STORE: begin
                d_s.alu_op.ADD = 1'b1;
                d_s.in1        = rs1_data;
                d_s.in2        = imm_s_s;
                illegal_s      = !store_f3_ok(f3_s);
            end
            default: illegal_s = 1'b1;
        endcase

        if (illegal_s) begin
            d_s         = '0;
            d_s.illegal = 1'b1;
        end else begin
            d_s.illegal = 1'b0;
        end

        // rd only carries meaning when the result is written back.
        if (d_s.reg_write) begin
            d_s.rd = instr[11:7];
        end else begin
            d_s.rd = 5'd0;
        end
    end

    assign dec = d_s;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: decodes one instruction per handshake into a
// registered output slot that drives the ALU inputs directly.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake (in_ready = slot empty or draining)
//   instr, pc, rs*_data : instruction and its operands
//   flush               : drop the held and the incoming instruction
//   out_valid/out_ready : downstream handshake
//   alu_op, alu_in*     : one-hot ALU control and operands
//   rd, reg_write, is_branch, branch_invert, is_jump, illegal : side-band flags
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = XLEN_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [XLEN-1:0]     alu_in1,
    output logic [XLEN-1:0]     alu_in2,
    output logic [XLEN-1:0]     alu_in1_b,
    output logic [XLEN-1:0]     alu_in2_b,
    output logic [4:0]          rd,
    output logic                reg_write,
    output logic                is_branch,
    output logic                branch_invert,
    output logic                is_jump,
    output logic                illegal
);

    decoded_instr_t dec_s;
    decoded_instr_t slot_r;
    logic           valid_r;
    logic           load_s;

    alu_instr_decoder u_decoder (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dec      (dec_s)
    );

    assign in_ready = !valid_r || out_ready;
    assign load_s   = in_valid && in_ready && !flush;

    // Slot occupancy: flush wins, then a new load, then consumption empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load_s) begin
            valid_r <= 1'b1;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Payload only changes on a load, so a stalled slot stays stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_r <= '0;
        end else if (load_s) begin
            slot_r <= dec_s;
        end else begin
            slot_r <= slot_r;
        end
    end

    assign out_valid     = valid_r;
    assign alu_op        = slot_r.alu_op;
    assign alu_in1       = slot_r.in1;
    assign alu_in2       = slot_r.in2;
    assign alu_in1_b     = slot_r.in1_b;
    assign alu_in2_b     = slot_r.in2_b;
    assign rd            = slot_r.rd;
    assign reg_write     = slot_r.reg_write;
    assign is_branch     = slot_r.is_branch;
    assign branch_invert = slot_r.branch_invert;
    assign is_jump       = slot_r.is_jump;
    assign illegal       = slot_r.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

    // Hand-assigned one-hot codes (bit 12 = ADD ... bit 0 = SLTU_B).
    localparam logic [12:0] OP_ADD   = 13'h1000;
    localparam logic [12:0] OP_SUB   = 13'h0800;
    localparam logic [12:0] OP_SRA   = 13'h0020;
    localparam logic [12:0] OP_SEQ_B = 13'h0004;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_in1_b;
    logic [31:0] alu_in2_b;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic        branch_invert;
    logic        is_jump;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] tmp;

    alu_issue_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .pc            (pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_op        (alu_op),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .alu_in1_b     (alu_in1_b),
        .alu_in2_b     (alu_in2_b),
        .rd            (rd),
        .reg_write     (reg_write),
        .is_branch     (is_branch),
        .branch_invert (branch_invert),
        .is_jump       (is_jump),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        instr     = 32'h0000_0013;
        pc        = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_op", {19'd0, alu_op}, 32'd0);
        chk("rst_in1", alu_in1, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_flags", {26'd0, reg_write, is_branch, branch_invert, is_jump, illegal, 1'b0}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;

        // add x3,x1,x2
        instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_op", {19'd0, alu_op}, {19'd0, OP_ADD});
        chk("add_in1", alu_in1, 32'd5);
        chk("add_in2", alu_in2, 32'd7);
        chk("add_rd", {27'd0, rd}, 32'd3);
        chk("add_wr", {31'd0, reg_write}, 32'd1);
        chk("add_out", alu_in1 + alu_in2, 32'd12);

        // sub, then srai back-to-back
        instr = 32'h402081B3;
        step();
        chk("sub_op", {19'd0, alu_op}, {19'd0, OP_SUB});
        chk("sub_ops", {alu_in1[15:0], alu_in2[15:0]}, 32'h0005_0007);
        chk("sub_out", alu_in1 - alu_in2, 32'hFFFF_FFFE);
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        instr = 32'h40435293; rs1_data = 32'h8000_0000;
        step();
        chk("sra_op", {19'd0, alu_op}, {19'd0, OP_SRA});
        chk("sra_in2", alu_in2, 32'd4);
        chk("sra_rd", {27'd0, rd}, 32'd5);
        tmp = $signed(alu_in1) >>> alu_in2[4:0];
        chk("sra_out", tmp, 32'hF800_0000);

        // beq x1,x2,+8
        instr = 32'h00208463; pc = 32'h100; rs1_data = 32'd9; rs2_data = 32'd9;
        step();
        chk("beq_op", {19'd0, alu_op}, {19'd0, OP_ADD | OP_SEQ_B});
        chk("beq_in1", alu_in1, 32'h100);
        chk("beq_in2", alu_in2, 32'd8);
        chk("beq_b", {alu_in1_b[15:0], alu_in2_b[15:0]}, 32'h0009_0009);
        chk("beq_flags", {27'd0, reg_write, is_branch, branch_invert, is_jump, illegal}, 32'b01000);
        chk("beq_rd", {27'd0, rd}, 32'd0);
        chk("beq_target", alu_in1 + alu_in2, 32'h108);
        chk("beq_out_b", {31'd0, alu_in1_b == alu_in2_b}, 32'd1);

        // bne x1,x2,+8 sets the inversion flag
        instr = 32'h00209463;
        step();
        chk("bne_op", {19'd0, alu_op}, {19'd0, OP_ADD | OP_SEQ_B});
        chk("bne_inv", {31'd0, branch_invert}, 32'd1);

        // jal x1,-4 at pc 0x200: negative J-immediate
        instr = 32'hFFDFF0EF; pc = 32'h200;
        step();
        chk("jal_in1", alu_in1, 32'h200);
        chk("jal_in2", alu_in2, 32'hFFFF_FFFC);
        chk("jal_flags", {27'd0, reg_write, is_branch, branch_invert, is_jump, illegal}, 32'b10010);
        chk("jal_rd", {27'd0, rd}, 32'd1);

        // drain
        in_valid = 1'b0;
        step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // lui x1,0x12345 stalled for 3 cycles while another instr waits
        instr = 32'h123450B7; in_valid = 1'b1; out_ready = 1'b0;
        step();
        instr = 32'hFFF00113; rs1_data = 32'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_in1", alu_in1, 32'd0);
            chk("stall_in2", alu_in2, 32'h1234_5000);
            chk("stall_rd", {27'd0, rd}, 32'd1);
            chk("stall_op", {19'd0, alu_op}, {19'd0, OP_ADD});
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("addi_in1", alu_in1, 32'h10);
        chk("addi_in2", alu_in2, 32'hFFFF_FFFF);
        chk("addi_rd", {27'd0, rd}, 32'd2);

        // flush with in_valid while slot is full
        out_ready = 1'b0; flush = 1'b1; instr = 32'h123450B7;
        step();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;

        // async reset during a stall
        instr = 32'h002081B3;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
        chk("async_reset_op", {19'd0, alu_op}, 32'd0);
        reset = 1'b0;

        // all-ones word is illegal
        instr = 32'hFFFFFFFF; in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_op", {19'd0, alu_op}, 32'd0);
        chk("ill_wr", {31'd0, reg_write}, 32'd0);
        chk("ill_in", alu_in1 | alu_in2, 32'd0);

        // branch funct3 010 is reserved
        instr = 32'h0020A463;
        step();
        chk("br010_ill", {31'd0, illegal}, 32'd1);
        chk("br010_op", {19'd0, alu_op}, 32'd0);
        chk("br010_branch", {31'd0, is_branch}, 32'd0);

        in_valid = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Pipeline stage directly upstream of the ArithmeticLogicUnit. It accepts one fetched RV32I instruction per handshake, plus its PC and the two register-file read values. It decodes the instruction into the one-hot InstructionSetALU control word and selects both primary and secondary operands. The result is held in a registered, valid/ready-handshaked output slot that drives the ALU inputs directly.

Parameters:
XLEN, 32, datapath width of pc, register data and ALU operands.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream has an instruction
in_ready  output  1  stage can accept this cycle
instr  input  32  RV32I instruction word
pc  input  XLEN  address of instr
rs1_data  input  XLEN  register value for instr[19:15]
rs2_data  input  XLEN  register value for instr[24:20]
flush  input  1  discard held and incoming instruction
out_valid  output  1  output slot holds a decoded instruction
out_ready  input  1  downstream consumes this cycle
alu_op  output  $bits(InstructionSetALU)  one-hot ALU control to ArithmeticLogicUnit.op
alu_in1  output  XLEN  to ALU in1
alu_in2  output  XLEN  to ALU in2
alu_in1_b  output  XLEN  to ALU in1_b
alu_in2_b  output  XLEN  to ALU in2_b
rd  output  5  destination register
reg_write  output  1  result is written to rd
is_branch  output  1  out_b decides a conditional branch
branch_invert  output  1  taken when out_b==0 (BNE/BGE/BGEU)
is_jump  output  1  JAL/JALR
illegal  output  1  unrecognised encoding

Behaviour:
- Reset, asynchronous: out_valid=0. alu_op, all operands, rd, and all flags are 0.
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- Load condition: in_valid && in_ready && !flush. The slot captures the decoded fields on the next edge, giving a latency of 1 cycle.
- Consumption: if out_valid && out_ready and there is no new load, out_valid goes to 0.
- flush has priority. On the next edge out_valid=0 regardless of in_valid or out_ready, and the incoming instruction is dropped. Data fields may hold stale values.
- Payload fields change only on load. While out_valid && !out_ready, every output stays stable.
- Back-to-back operation: with out_ready=1 continuously, one instruction is accepted per cycle.
- Decode by opcode. Unlisted fields are 0, and only one ALU primary bit is ever set.
  - OP 0110011: funct3/funct7[5] selects ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. in1=rs1_data, in2=rs2_data, reg_write=1.
  - OP-IMM 0010011: same ops, excluding SUB. in2 = sign-extended I-imm. For SLLI/SRLI/SRAI, in2 = zero-extended shamt instr[24:20], and funct7[5] selects SRA. reg_write=1.
  - LUI: ADD, in1=0, in2={instr[31:12],12'b0}, reg_write=1.
  - AUIPC: ADD, in1=pc, in2 = U-imm, reg_write=1.
  - JAL: ADD, in1=pc, in2 = sign-extended J-imm, is_jump=1, reg_write=1.
  - JALR: ADD, in1=rs1_data, in2 = I-imm, is_jump=1, reg_write=1.
  - BRANCH: ADD, in1=pc, in2 = sign-extended B-imm (the target), in1_b=rs1_data, in2_b=rs2_data, is_branch=1, reg_write=0.
    - BEQ and BNE set SEQ_B.
    - BLT and BGE set SLT_B.
    - BLTU and BGEU set SLTU_B.
    - branch_invert=1 for BNE, BGE, BGEU.
  - LOAD: ADD rs1_data + I-imm, reg_write=1.
  - STORE: ADD rs1_data + S-imm, reg_write=0.
  - Anything else: includes reserved funct3/funct7 and branch funct3 010/011. alu_op=0 (NOP), illegal=1, reg_write=0. Still handshaked normally.
- rd=instr[11:7] for reg_write instructions, else 0.
- Writes to x0 keep reg_write=1; the register file ignores them.
- Reset asserted mid-stall clears out_valid immediately, without waiting for a clock edge.

Decomposition:
- Shared package:
  - InstructionSetALU, unchanged.
  - Opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE.
  - funct3 constants.
  - A decoded_instr_t struct holding alu_op, the four operands, rd, and the flags.
- Sub-module alu_instr_decoder: purely combinational, instr/pc/rs data to decoded_instr_t. Its output feeds the alu_issue_stage register.

Test Plan:
1. add x3,x1,x2 = 0x002081B3, rs1_data=5, rs2_data=7, out_ready=1 -> next cycle: out_valid=1, alu_op.ADD only, in1=5, in2=7, rd=3, reg_write=1. Feeding the ALU gives out=12.
2. sub 0x402081B3 with rs1=5, rs2=7, then srai x5,x6,4 = 0x40435293 with rs1=0x80000000 -> SUB with in1=5, in2=7; then SRA with in2=4. ALU results 0xFFFFFFFE and 0xF8000000.
3. beq x1,x2,+8 = 0x00208463, pc=0x100, rs1=rs2=9 -> ADD with in1=0x100, in2=8; SEQ_B; in1_b=in2_b=9; is_branch=1, branch_invert=0. ALU gives out=0x108, out_b=1.
4. lui x1,0x12345 = 0x123450B7 held with out_ready=0 for 3 cycles -> outputs stable, in_ready=0. With out_ready=1: in_ready=1, and a new instr loads next cycle.
5. flush asserted together with in_valid while the slot is full -> next cycle out_valid=0. Also check asynchronous reset during a stall -> out_valid=0 before the next edge.
6. instr 0xFFFFFFFF -> illegal=1, alu_op=0, reg_write=0. The ALU outputs 0 and out_b 0.
